// File: rtl/uart_byte_receive.sv
// 8N1 UART receiver that realigns bytes into NUM_BYTES x 7-bit words using bit 7 as the
// word-alignment flag. Optional idle timeout for partial words: UART_BYTE_RX_TIMEOUT_EN.
module uart_byte_receive #(
    parameter int NUM_BYTES        = 2,
    parameter int BAUD_RATE        = 9600,
    parameter int INPUT_CLOCK_FREQ = 100_000_000
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rx_wire_in,
    output logic [NUM_BYTES-1:0][6:0]  data_out,
    output logic                       valid_out,
    output logic                       error_out,
    output logic                       busy_out
);
    // state | meaning
    // IDLE  | line idle, waiting for a falling edge
    // START | timing to mid start bit to reject glitches
    // DATA  | sampling 8 data bits at mid-bit, LSB first
    // STOP  | sampling the stop bit at mid-bit
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

    localparam int BAUD_COUNT = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W      = $clog2(BAUD_COUNT) + 1;
    localparam int POS_W      = $clog2(NUM_BYTES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_COUNT / 2);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_BYTES - 1);

    rx_state_t              state, state_next;
    logic                   sync1, sync2;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [2:0]             bit_idx, bit_next;
    logic [7:0]             shreg, shreg_next;
    logic                   byte_done, stop_err, start_det;
    logic [POS_W-1:0]       position, pos_next;
    logic [NUM_BYTES-1:0][6:0] slots, slots_next;
    logic                   commit, asm_err, timeout;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_wire_in;
            sync2 <= sync1;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shreg_next = shreg;
        byte_done  = 1'b0;
        stop_err   = 1'b0;
        start_det  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!sync2) begin
                    state_next = S_START;
                    cnt_next   = '0;
                    start_det  = 1'b1;
                end
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = sync2 ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {sync2, shreg[7:1]};
                    bit_next   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_next = S_STOP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                    byte_done  = sync2;
                    stop_err   = !sync2;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef UART_BYTE_RX_TIMEOUT_EN
    localparam int TO_COUNT = 20 * BAUD_COUNT;
    localparam int TO_W     = $clog2(TO_COUNT) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_COUNT - 1);
    logic [TO_W-1:0] idle_cnt;

    assign timeout = (state == S_IDLE) && !start_det && (position != '0) && (idle_cnt == TO_LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            idle_cnt <= '0;
        else if (state != S_IDLE || start_det || position == '0 || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // Word assembly; byte_done only fires in STOP, so it never coincides with a timeout.
    always_comb begin
        pos_next   = position;
        slots_next = slots;
        commit     = 1'b0;
        asm_err    = 1'b0;
        if (byte_done) begin
            if (!shreg[7]) begin
                asm_err       = (position != '0);
                slots_next[0] = shreg[6:0];
                pos_next      = POS_W'(1);
            end else if (position == '0) begin
                asm_err = 1'b1;
            end else begin
                for (int i = 1; i < NUM_BYTES; i++)
                    if (position == POS_W'(i)) slots_next[i] = shreg[6:0];
                if (position == POS_LAST) begin
                    commit   = 1'b1;
                    pos_next = '0;
                end else begin
                    pos_next = position + 1'b1;
                end
            end
        end
        if (timeout) pos_next = '0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            position  <= '0;
            slots     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error_out <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_next;
            shreg     <= shreg_next;
            position  <= pos_next;
            slots     <= slots_next;
            if (commit) data_out <= slots_next;
            valid_out <= commit;
            error_out <= stop_err | asm_err | timeout;
            busy_out  <= (state_next != S_IDLE) || (pos_next != '0);
        end
    end
endmodule

// File: tb/tb_uart_byte_receive.sv
// Scoreboard bench for uart_byte_receive: directed word scenarios plus randomized bytes,
// expected events predicted from the byte-level framing rules.
module tb_uart_byte_receive;
    localparam int NB     = 2;
    localparam int CLK_HZ = 100_000_000;
    localparam int BAUD   = 10_000_000;
    localparam int BC     = CLK_HZ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic [NB-1:0][6:0] dout;
    logic valid, err, busy;

    uart_byte_receive #(.NUM_BYTES(NB), .BAUD_RATE(BAUD), .INPUT_CLOCK_FREQ(CLK_HZ)) dut (
        .clk_in(clk), .rst_in(rst), .rx_wire_in(rx),
        .data_out(dout), .valid_out(valid), .error_out(err), .busy_out(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [13:0] word;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [6:0] m_slots[NB];
    int         m_pos    = 0;
    logic [13:0] m_word  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic push_ev(input logic is_err);
        ev_t e;
        e.is_err = is_err;
        e.word   = m_word;
        exp_q.push_back(e);
    endtask

    // Reference: a byte either fails framing, restarts a word, is orphaned, or fills the next slot.
    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            push_ev(1'b1);
        end else if (!b[7]) begin
            if (m_pos != 0) push_ev(1'b1);
            m_slots[0] = b[6:0];
            m_pos = 1;
        end else if (m_pos == 0) begin
            push_ev(1'b1);
        end else begin
            m_slots[m_pos] = b[6:0];
            if (m_pos == NB - 1) begin
                m_word = {m_slots[1], m_slots[0]};
                push_ev(1'b0);
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        rx = 1'b0;
        repeat (BC) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BC) @(posedge clk);
        end
        rx = stop_ok;
        repeat (BC) @(posedge clk);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
`ifdef UART_BYTE_RX_TIMEOUT_EN
        if (n >= 20 && m_pos != 0) begin
            push_ev(1'b1);
            m_pos = 0;
        end
`endif
        repeat (n * BC) @(posedge clk);
    endtask

    task automatic drain();
        int budget = 500;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst && (valid || err)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'd0, err, valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", {30'd0, err, valid}, e.is_err ? 32'd2 : 32'd1);
                    check("event_data", 32'(dout), 32'(e.word));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit         ok;
        int         gap;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(dout), 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_error", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle_bits(2);

        send_byte(8'h35, 1'b1);
        send_byte(8'hAB, 1'b1);
        idle_bits(3);
        drain();
        @(negedge clk);
        check("s1_busy", {31'd0, busy}, 32'd0);
        check("s1_word", 32'(dout), 32'({7'h2B, 7'h35}));

        send_byte(8'h35, 1'b1);
        send_byte(8'h9F, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h80, 1'b1);
        idle_bits(3);
        drain();

        send_byte(8'h35, 1'b0);
        idle_bits(2);
        send_byte(8'h11, 1'b1);
        send_byte(8'h81, 1'b1);
        idle_bits(3);
        drain();

        send_byte(8'hC4, 1'b1);
        idle_bits(2);
        drain();
        check("s4_hold", 32'(dout), 32'({7'h01, 7'h11}));
        send_byte(8'h05, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'h81, 1'b1);
        idle_bits(3);
        drain();

        rx = 1'b0;
        repeat (3) @(posedge clk);
        rx = 1'b1;
        idle_bits(3);
        @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'd0);

        rx = 1'b0;
        repeat (BC) @(posedge clk);
        rx = 1'b1;
        repeat (BC) @(posedge clk);
        rx = 1'b0;
        repeat (BC) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(dout), 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        m_pos  = 0;
        m_word = '0;
        repeat (3) @(posedge clk);
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_bits(3);
        send_byte(8'h4D, 1'b1);
        send_byte(8'hE6, 1'b1);
        idle_bits(3);
        drain();

        send_byte(8'h22, 1'b1);
        idle_bits(25);
        @(negedge clk);
`ifdef UART_BYTE_RX_TIMEOUT_EN
        check("partial_busy", {31'd0, busy}, 32'd0);
`else
        check("partial_busy", {31'd0, busy}, 32'd1);
`endif
        send_byte(8'hAB, 1'b1);
        idle_bits(3);
        drain();

        for (int n = 0; n < 30; n++) begin
            b    = 8'($urandom);
            b[7] = (m_pos != 0);
            if ($urandom_range(0, 5) == 0) b[7] = ~b[7];
            ok   = ($urandom_range(0, 7) != 0);
            gap  = ok ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 3));
            send_byte(b, ok);
            if (gap > 0) idle_bits(gap);
        end
        idle_bits(3);
        drain();
        @(negedge clk);
        check("final_hold", 32'(dout), 32'(m_word));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
